// File: rtl/full_adder_pkg.sv
// Shared constants and a reference model for the ripple-carry adder.
// Optional signed-overflow output is enabled by defining FULL_ADDER_OVF_EN.
package full_adder_pkg;

   localparam int FA_DEFAULT_WIDTH = 1;
   localparam int FA_MAX_WIDTH     = 64;

   // Golden {c, s} for operands zero-extended to the maximum width.
   function automatic logic [FA_MAX_WIDTH:0] fa_ref(
      input logic [FA_MAX_WIDTH-1:0] a,
      input logic [FA_MAX_WIDTH-1:0] b,
      input logic                    cin
   );
      return {1'b0, a} + {1'b0, b} + {{FA_MAX_WIDTH{1'b0}}, cin};
   endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder cell, the building block of the ripple chain.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder.sv
// Parameterizable ripple-carry adder with optional output register and valid.
// Define FULL_ADDER_OVF_EN to add the signed overflow output ovf.
module full_adder
   import full_adder_pkg::*;
#(
   parameter int WIDTH   = FA_DEFAULT_WIDTH,
   parameter bit REG_OUT = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] s,
   output logic             c,
   output logic             out_valid
`ifdef FULL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum;

   if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_bad_width
      $error("full_adder: WIDTH out of range 1..64");
   end

   assign carry[0] = cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      fa_cell u_cell (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (carry[i]),
         .s    (sum[i]),
         .cout (carry[i+1])
      );
   end

`ifdef FULL_ADDER_OVF_EN
   logic ovf_comb;

   // Signed overflow: carry into the MSB disagrees with carry out of it.
   assign ovf_comb = carry[WIDTH-1] ^ carry[WIDTH];
`endif

   if (REG_OUT) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            s         <= '0;
            c         <= 1'b0;
            out_valid <= 1'b0;
`ifdef FULL_ADDER_OVF_EN
            ovf       <= 1'b0;
`endif
         end else begin
            out_valid <= in_valid;
            if (in_valid) begin
               s <= sum;
               c <= carry[WIDTH];
`ifdef FULL_ADDER_OVF_EN
               ovf <= ovf_comb;
`endif
            end
         end
      end
   end else begin : g_comb
      // Clock and reset are intentionally ignored in the combinational build.
      logic unused_clk_rst;

      assign unused_clk_rst = clk ^ rst;
      assign s              = sum;
      assign c              = carry[WIDTH];
      assign out_valid      = in_valid;
`ifdef FULL_ADDER_OVF_EN
      assign ovf            = ovf_comb;
`endif
   end

endmodule

// File: tb/tb_full_adder.sv
// Directed self-checking bench for full_adder in registered and combinational builds.
// Overflow checks are compiled in when FULL_ADDER_OVF_EN is defined.
module tb_full_adder;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic       v1_in = 1'b0, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
   logic       s1, c1, v1_out;

   logic       v8_in = 1'b0, cin8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic [7:0] s8;
   logic       c8, v8_out;

   logic       v4_in = 1'b0, cin4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic [3:0] s4;
   logic       c4, v4_out;

`ifdef FULL_ADDER_OVF_EN
   logic ovf1, ovf8, ovf4;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   full_adder #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (
      .clk(clk), .rst(rst), .in_valid(v1_in), .a(a1), .b(b1), .cin(cin1),
      .s(s1), .c(c1), .out_valid(v1_out)
`ifdef FULL_ADDER_OVF_EN
      , .ovf(ovf1)
`endif
   );

   full_adder #(.WIDTH(8), .REG_OUT(1'b1)) u_w8 (
      .clk(clk), .rst(rst), .in_valid(v8_in), .a(a8), .b(b8), .cin(cin8),
      .s(s8), .c(c8), .out_valid(v8_out)
`ifdef FULL_ADDER_OVF_EN
      , .ovf(ovf8)
`endif
   );

   full_adder #(.WIDTH(4), .REG_OUT(1'b0)) u_w4 (
      .clk(clk), .rst(rst), .in_valid(v4_in), .a(a4), .b(b4), .cin(cin4),
      .s(s4), .c(c4), .out_valid(v4_out)
`ifdef FULL_ADDER_OVF_EN
      , .ovf(ovf4)
`endif
   );

   // Drives one 8-bit operand set on the falling edge, ahead of the next rising edge.
   task automatic applyStimulus(input logic valid, input logic [7:0] a, input logic [7:0] b,
                                input logic cin);
      @(negedge clk);
      v8_in = valid;
      a8    = a;
      b8    = b;
      cin8  = cin;
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      v1_in = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
      v8_in = 1'b1; a8 = 8'h55; b8 = 8'h22; cin8 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({s1, c1, v1_out} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL reset_w1: got s/c/v=%b expected 000", {s1, c1, v1_out});
      end
      checks++;
      if ({s8, c8, v8_out} !== 10'b0) begin
         errors++;
         $display("[TB] FAIL reset_w8: got s=%h c=%b v=%b expected s=00 c=0 v=0", s8, c8, v8_out);
      end
      @(negedge clk);
      rst   = 1'b0;
      v1_in = 1'b0;
      v8_in = 1'b0;
   endtask

   task automatic test_truth_table();
      logic [1:0] exp_cs [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
      for (int i = 0; i < 8; i++) begin
         logic [2:0] abc;
         abc = 3'(i);
         @(negedge clk);
         v1_in = 1'b1;
         {a1, b1, cin1} = abc;
         @(posedge clk);
         #1;
         checks++;
         if ({c1, s1, v1_out} !== {exp_cs[i], 1'b1}) begin
            errors++;
            $display("[TB] FAIL truth_row_%0d: got c=%b s=%b v=%b expected c=%b s=%b v=1",
                     i, c1, s1, v1_out, exp_cs[i][1], exp_cs[i][0]);
         end
      end
      @(negedge clk);
      v1_in = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (v1_out !== 1'b0 || s1 !== 1'b1 || c1 !== 1'b1) begin
         errors++;
         $display("[TB] FAIL truth_hold: got s=%b c=%b v=%b expected s=1 c=1 v=0", s1, c1, v1_out);
      end
   endtask

   task automatic test_wide();
      logic [7:0] va [3] = '{8'hFF, 8'hFF, 8'h00};
      logic [7:0] vb [3] = '{8'h01, 8'hFF, 8'h00};
      logic       vc [3] = '{1'b0, 1'b1, 1'b1};
      logic [7:0] es [3] = '{8'h00, 8'hFF, 8'h01};
      logic       ec [3] = '{1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, va[i], vb[i], vc[i]);
         @(posedge clk);
         #1;
         checks++;
         if (s8 !== es[i] || c8 !== ec[i] || v8_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wide_%0d: got s=%h c=%b v=%b expected s=%h c=%b v=1",
                     i, s8, c8, v8_out, es[i], ec[i]);
         end
      end
   endtask

   task automatic test_hold();
      applyStimulus(1'b1, 8'h12, 8'h34, 1'b0);
      @(posedge clk);
      #1;
      checks++;
      if (s8 !== 8'h46 || c8 !== 1'b0 || v8_out !== 1'b1) begin
         errors++;
         $display("[TB] FAIL hold_load: got s=%h c=%b v=%b expected s=46 c=0 v=1", s8, c8, v8_out);
      end
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 8'hF0 + 8'(i), 8'h3C, 1'b1);
         @(posedge clk);
         #1;
         checks++;
         if (s8 !== 8'h46 || c8 !== 1'b0 || v8_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_gap_%0d: got s=%h c=%b v=%b expected s=46 c=0 v=0",
                     i, s8, c8, v8_out);
         end
      end
   endtask

   task automatic test_async_reset();
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (s8 !== 8'h00 || c8 !== 1'b0 || v8_out !== 1'b0) begin
         errors++;
         $display("[TB] FAIL async_reset: got s=%h c=%b v=%b expected s=00 c=0 v=0", s8, c8, v8_out);
      end
      @(negedge clk);
      rst  = 1'b0;
      v8_in = 1'b1; a8 = 8'h01; b8 = 8'h01; cin8 = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (s8 !== 8'h03 || c8 !== 1'b0 || v8_out !== 1'b1) begin
         errors++;
         $display("[TB] FAIL post_reset: got s=%h c=%b v=%b expected s=03 c=0 v=1", s8, c8, v8_out);
      end
   endtask

   task automatic test_comb();
      @(negedge clk);
      v4_in = 1'b1; a4 = 4'hA; b4 = 4'h7; cin4 = 1'b0;
      #1;
      checks++;
      if (s4 !== 4'h1 || c4 !== 1'b1 || v4_out !== 1'b1) begin
         errors++;
         $display("[TB] FAIL comb_add: got s=%h c=%b v=%b expected s=1 c=1 v=1", s4, c4, v4_out);
      end
      v4_in = 1'b0; a4 = 4'h3; b4 = 4'h4; cin4 = 1'b1;
      #1;
      checks++;
      if (s4 !== 4'h8 || c4 !== 1'b0 || v4_out !== 1'b0) begin
         errors++;
         $display("[TB] FAIL comb_invalid: got s=%h c=%b v=%b expected s=8 c=0 v=0", s4, c4, v4_out);
      end
      rst   = 1'b1;
      v4_in = 1'b1;
      #1;
      checks++;
      if (s4 !== 4'h8 || c4 !== 1'b0 || v4_out !== 1'b1) begin
         errors++;
         $display("[TB] FAIL comb_rst_ignored: got s=%h c=%b v=%b expected s=8 c=0 v=1", s4, c4, v4_out);
      end
      @(negedge clk);
      rst   = 1'b0;
      v4_in = 1'b0;
   endtask

`ifdef FULL_ADDER_OVF_EN
   task automatic test_ovf();
      logic [7:0] va  [3] = '{8'h7F, 8'h80, 8'hFF};
      logic [7:0] vb  [3] = '{8'h01, 8'h80, 8'h01};
      logic [7:0] es  [3] = '{8'h80, 8'h00, 8'h00};
      logic       ec  [3] = '{1'b0, 1'b1, 1'b1};
      logic       eov [3] = '{1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, va[i], vb[i], 1'b0);
         @(posedge clk);
         #1;
         checks++;
         if (s8 !== es[i] || c8 !== ec[i] || ovf8 !== eov[i]) begin
            errors++;
            $display("[TB] FAIL ovf_%0d: got s=%h c=%b ovf=%b expected s=%h c=%b ovf=%b",
                     i, s8, c8, ovf8, es[i], ec[i], eov[i]);
         end
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (ovf8 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ovf_reset: got ovf=%b expected 0", ovf8);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask
`endif

   initial begin
      $display("[TB] starting full_adder bench");
      test_reset();
      test_truth_table();
      test_wide();
      test_hold();
      test_async_reset();
      test_comb();
`ifdef FULL_ADDER_OVF_EN
      test_ovf();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
